// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide (shift-add, restoring divide).
// Define MULDIV_FASTPATH_EN to let special cases bypass the iteration phase.
module muldiv_seq #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [3:0]  mulOp,
   input  logic [63:0] ia,
   input  logic [63:0] ib,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   localparam logic [6:0] CNT_D = 7'(64 / BITS_PER_CYCLE);
   localparam logic [6:0] CNT_W = 7'(32 / BITS_PER_CYCLE);

   state_t      state_q, state_d;
   logic [63:0] a_q, a_d, b_q, b_d;
   logic [63:0] araw_q, araw_d, res_q, res_d;
   logic [64:0] r_q, r_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        word_q, word_d, div_q, div_d, rem_q, rem_d;
   logic        inv_q, inv_d, divz_q, divz_d, ovf_q, ovf_d;

   logic        in_word, in_div, in_rem, in_sgn;
   logic        sa, sb, bzero, amin, bm1, fast;
   logic [31:0] a32m, b32m;
   logic [63:0] mag_a, mag_b, opa, opb;

   always_comb begin
      in_word = mulOp[3];
      in_div  = mulOp[2];
      in_rem  = mulOp[2] & mulOp[1];
      in_sgn  = mulOp[2] & ~mulOp[0];
      sa      = in_word ? ia[31] : ia[63];
      sb      = in_word ? ib[31] : ib[63];
      a32m    = ia[31] ? -ia[31:0] : ia[31:0];
      b32m    = ib[31] ? -ib[31:0] : ib[31:0];
      mag_a   = in_word ? {32'd0, a32m} : (ia[63] ? -ia : ia);
      mag_b   = in_word ? {32'd0, b32m} : (ib[63] ? -ib : ib);
      opa     = in_sgn ? mag_a : (in_word ? {32'd0, ia[31:0]} : ia);
      opb     = in_sgn ? mag_b : (in_word ? {32'd0, ib[31:0]} : ib);
      bzero   = in_word ? (ib[31:0] == '0) : (ib == '0);
      amin    = in_word ? (ia[31:0] == 32'h8000_0000)
                        : (ia == 64'h8000_0000_0000_0000);
      bm1     = in_word ? (ib[31:0] == '1) : (ib == '1);
`ifdef MULDIV_FASTPATH_EN
      fast    = (in_div & bzero) | (in_sgn & amin & bm1) |
                (in_word ? (ia[31:0] == '0) : (ia == '0));
`else
      fast    = 1'b0;
`endif
   end

   // one iteration step, unrolled BITS_PER_CYCLE times
   logic [63:0] st_a, st_b;
   logic [64:0] st_r;

   always_comb begin
      st_a = a_q;
      st_b = b_q;
      st_r = r_q;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (div_q) begin
            st_r = {st_r[63:0], st_a[63]};
            st_a = {st_a[62:0], 1'b0};
            if (st_r >= {1'b0, b_q}) begin
               st_r    = st_r - {1'b0, b_q};
               st_a[0] = 1'b1;
            end
         end else begin
            if (st_b[0]) st_r = st_r + {1'b0, st_a};
            st_a = {st_a[62:0], 1'b0};
            st_b = {1'b0, st_b[63:1]};
         end
      end
   end

   logic [63:0] sel, fixv;

   always_comb begin
      sel  = (div_q & ~rem_q) ? a_q : r_q[63:0];
      fixv = inv_q ? -sel : sel;
      if (divz_q)     fixv = rem_q ? araw_q : '1;
      else if (ovf_q) fixv = rem_q ? '0 : araw_q;
      if (word_q)     fixv = {{32{fixv[31]}}, fixv[31:0]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      araw_d  = araw_q;
      res_d   = res_q;
      word_d  = word_q;
      div_d   = div_q;
      rem_d   = rem_q;
      inv_d   = inv_q;
      divz_d  = divz_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               a_d     = (in_div & in_word) ? {opa[31:0], 32'd0} : opa;
               b_d     = opb;
               r_d     = '0;
               cnt_d   = in_word ? CNT_W : CNT_D;
               araw_d  = ia;
               word_d  = in_word;
               div_d   = in_div;
               rem_d   = in_rem;
               inv_d   = in_sgn & (in_rem ? sa : (sa ^ sb));
               divz_d  = in_div & bzero;
               ovf_d   = in_sgn & amin & bm1;
               state_d = fast ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            a_d   = st_a;
            b_d   = st_b;
            r_d   = st_r;
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) state_d = S_FIX;
         end
         S_FIX: begin
            res_d   = fixv;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
      endcase
      // a kill must leave the previously delivered result intact
      if (flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         araw_q  <= '0;
         res_q   <= '0;
         word_q  <= 1'b0;
         div_q   <= 1'b0;
         rem_q   <= 1'b0;
         inv_q   <= 1'b0;
         divz_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         araw_q  <= araw_d;
         res_q   <= res_d;
         word_q  <= word_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         inv_q   <= inv_d;
         divz_q  <= divz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = res_q;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the execute stage. Accepts one RV64M operation per start pulse and computes it over multiple cycles with a shift-add multiplier and a restoring divider. Converts signed operands to magnitudes and fixes the result sign afterwards. Handles the RISC-V divide-by-zero and overflow rules, sign-extends word results, and exposes busy/done to the pipeline stall logic.

Parameters:
BITS_PER_CYCLE, 1, bits retired per iteration cycle; legal values 1, 2, 4; iteration count = N/BITS_PER_CYCLE with N=64 (double) or 32 (word).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
flush  input  1  pipeline kill; abort any operation
mulOp  input  4  bit3 = word op; [2:0]: 000 mul, 100 div, 101 divu, 110 rem, 111 remu; 001/010/011 treated as mul
ia  input  64  operand A (dividend / multiplicand); sampled with start
ib  input  64  operand B (divisor / multiplier); sampled with start
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse; result valid
result  output  64  final value; held until the next done

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, internal registers cleared. Reset mid-operation discards the operation with no done pulse.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1, flush=0: latch the op, magnitudes, inv flag and special-case flags; load cnt=N/BITS_PER_CYCLE; go to CALC.
- CALC: retire BITS_PER_CYCLE bits per cycle and decrement cnt; when cnt==1, go to FIX on the next cycle.
- FIX: select quotient, remainder or product; negate if inv; apply special cases; for word ops sign-extend bit 31; register result; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE. A start in DONE is ignored; the pipeline re-issues it.
- Latency: start sampled at cycle 0, CALC cycles 1..N/BPC, FIX at N/BPC+1, done at N/BPC+2. With BPC=1: 66 cycles for double ops, 34 for word ops.
- Operand prep, word ops: use ia[31:0] and ib[31:0]. Signed ops zero-extend the 32-bit magnitude; unsigned ops zero-extend the raw low word.
- Operand prep, double ops: signed ops use the 64-bit magnitude; unsigned ops use the raw value.
- mul/mulw: unsigned product of the raw operands, low N bits kept; inv=0.
- inv for div: sign(A) xor sign(B), taken at the 32-bit or 64-bit width. For rem: sign(A). For divu/remu/mul: 0.
- Divisor zero (ib==0, or ib[31:0]==0 for word ops): quotient = all ones; remainder = A (word: sign-extended ia[31:0]).
- Signed overflow (A = most negative value, B = -1, at the op width): quotient = A, remainder = 0. This applies to div/rem only, not to the unsigned variants.
- flush: in any non-IDLE state, go to IDLE next cycle; no done pulse; result unchanged. flush and start in the same IDLE cycle: flush wins, nothing launched.
- start while busy: ignored; the latched operands must not change.

Optional Feature:
MULDIV_FASTPATH_EN
- Defined: when divisor zero, signed overflow, or A==0 is detected at start, skip CALC and go IDLE -> FIX. done is asserted at cycle 2 after start.
- Undefined: these cases run the full iteration count with identical results and the standard latency.

Test Plan:
- mul, ia=7, ib=-3 (0xFFFFFFFFFFFFFFFD), BPC=1 -> done at cycle 66, result=0xFFFFFFFFFFFFFFEB.
- divw then remw, ia=-7, ib=2 -> done at cycle 34 each; results 0xFFFFFFFFFFFFFFFD and 0xFFFFFFFFFFFFFFFF.
- divu ia=100, ib=0 -> 0xFFFFFFFFFFFFFFFF; remu ia=100, ib=0 -> 100. With MULDIV_FASTPATH_EN, done at cycle 2.
- div ia=0x8000000000000000, ib=-1 -> result=0x8000000000000000; remw ia=0x80000000, ib=-1 -> result=0.
- start div 1000/7, then flush at cycle 20 -> no done pulse, busy=0 at cycle 21, result keeps its old value. A new start then gives 142.
- start div, then start again with different operands at cycles 5 and 40 -> both ignored; one done pulse with the original quotient. reset at cycle 30 of a second op -> done never asserted, result=0.
